alu_share_arbiter: RTL and testbench

//  Shares one 64-bit Y86-64 ALU (ADD/SUB/AND/XOR) between two requesters:

---
 rtl/y86_alu_pkg.sv | 35 +++
 rtl/alu64_core.sv | 50 +++++
 rtl/alu_share_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_alu_pkg.sv
// Shared definitions for the Y86-64 shared ALU slice:
// function codes, arbiter FSM states, condition-code bit positions.
package y86_alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_fun_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  function automatic logic [2:0] cc_pack(
    input logic zf,
    input logic sf,
    input logic of
  );
    logic [2:0] cc;
    cc        = '0;
    cc[CC_ZF] = zf;
    cc[CC_SF] = sf;
    cc[CC_OF] = of;
    return cc;
  endfunction

endpackage

// File: rtl/alu64_core.sv
// Combinational W-bit Y86-64 ALU: ADD/SUB/AND/XOR with ZF/SF/OF.
// SUB shares the adder as a + ~b + 1.
module alu64_core
  import y86_alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [1:0]   fun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic [2:0]   cc
);

  logic         is_add;
  logic         is_sub;
  logic         is_and;
  logic         is_xor;
  logic [W-1:0] bx;
  logic [W-1:0] sum;
  logic         of;

  always_comb begin
    is_add = (fun == ALU_ADD);
    is_sub = (fun == ALU_SUB);
    is_and = (fun == ALU_AND);
    is_xor = (fun == ALU_XOR);
    bx     = is_sub ? ~b : b;
    sum    = a + bx + W'(is_sub);
    result = '0;
    of     = 1'b0;
    unique case (1'b1)
      is_add: begin
        result = sum;
        of     = (a[W-1] == b[W-1]) &&
                 (sum[W-1] != a[W-1]);
      end
      is_sub: begin
        result = sum;
        of     = (a[W-1] != b[W-1]) &&
                 (sum[W-1] != a[W-1]);
      end
      is_and: result = a & b;
      is_xor: result = a ^ b;
      default: result = '0;
    endcase
    cc = cc_pack(result == '0, result[W-1], of);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one shared Y86-64 ALU:
// grant, latch operands, execute one cycle, hold tagged response.
module alu_share_arbiter
  import y86_alu_pkg::*;
#(
  parameter int W          = 64,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_fun,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_fun,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic [2:0]   rsp_cc
);

  arb_state_e   state;
  arb_state_e   state_nxt;
  logic         last_grant;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [1:0]   op_fun;
  logic         op_id;

  logic         win;
  logic         pick1;
  logic         gnt0;
  logic         gnt1;
  logic         gnt;
  logic [W-1:0] alu_res;
  logic [2:0]   alu_cc;

  // Port 1 wins only when alone, or on its round-robin turn.
  always_comb begin
    win   = (state == ST_IDLE) ||
            ((state == ST_RESP) && rsp_ready);
    pick1 = req1_valid &&
            (!req0_valid ||
             (!PRIO_FIXED && !last_grant));
    gnt1  = win && pick1;
    gnt0  = win && req0_valid && !pick1;
    gnt   = gnt0 || gnt1;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (gnt) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready)
          state_nxt = gnt ? ST_EXEC : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (gnt) last_grant <= gnt1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_fun <= '0;
      op_id  <= 1'b0;
    end else if (gnt) begin
      op_a   <= gnt1 ? req1_a : req0_a;
      op_b   <= gnt1 ? req1_b : req0_b;
      op_fun <= gnt1 ? req1_fun : req0_fun;
      op_id  <= gnt1;
    end
  end

  alu64_core #(
    .W (W)
  ) u_alu (
    .fun    (op_fun),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res),
    .cc     (alu_cc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cc     <= '0;
    end else if (state == ST_EXEC) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= op_id;
      rsp_result <= alu_res;
      rsp_cc     <= alu_cc;
    end else if ((state == ST_RESP) && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed corner cases
// plus randomized traffic against an occupancy-level reference model.
module tb_alu_share_arbiter;
  import y86_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic [1:0]  req0_fun;
  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic [1:0]  req1_fun;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [63:0] rsp_result;
  logic [2:0]  rsp_cc;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .W          (64),
    .PRIO_FIXED (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_fun   (req0_fun),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_fun   (req1_fun),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cc     (rsp_cc)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one slot in flight, one response slot.
  logic        m_rv, m_id, m_fl, m_fl_id, m_last;
  logic [63:0] m_res, m_fl_res;
  logic [2:0]  m_cc, m_fl_cc;
  logic        g0, g1;

  function automatic logic [66:0] ref_op(logic [1:0] f, logic [63:0] a, logic [63:0] b);
    logic [64:0] s;
    logic [63:0] r;
    logic        of;
    s  = '0;
    of = 1'b0;
    case (f)
      2'b00: begin s = {a[63], a} + {b[63], b}; r = s[63:0]; of = s[64] ^ s[63]; end
      2'b01: begin s = {a[63], a} - {b[63], b}; r = s[63:0]; of = s[64] ^ s[63]; end
      2'b10: r = a & b;
      default: r = a ^ b;
    endcase
    return {(r == 64'd0), r[63], of, r};
  endfunction

  task automatic model_reset();
    m_rv = 1'b0; m_fl = 1'b0; m_last = 1'b1;
    m_id = 1'b0; m_res = '0; m_cc = '0;
    g0 = 1'b0; g1 = 1'b0;
  endtask

  task automatic drv(logic v0, logic [63:0] a0, logic [63:0] b0, logic [1:0] f0,
                     logic v1, logic [63:0] a1, logic [63:0] b1, logic [1:0] f1,
                     logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_fun = f0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_fun = f1;
    rsp_ready  = rr;
  endtask

  // Called at a negedge with inputs already set; returns at next negedge.
  task automatic step();
    logic        win, e0, e1;
    logic [66:0] r;
    #1;
    win = !m_fl && (!m_rv || rsp_ready);
    e0  = win && req0_valid && (!req1_valid || m_last);
    e1  = win && req1_valid && (!req0_valid || !m_last);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("rsp_valid", rsp_valid, m_rv);
    if (m_rv) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_cc", rsp_cc, m_cc);
    end
    g0 = e0; g1 = e1;
    if (m_fl) begin
      m_rv = 1'b1; m_id = m_fl_id; m_res = m_fl_res; m_cc = m_fl_cc;
    end else if (m_rv && rsp_ready) begin
      m_rv = 1'b0;
    end
    m_fl = e0 || e1;
    if (m_fl) begin
      r = e1 ? ref_op(req1_fun, req1_a, req1_b)
             : ref_op(req0_fun, req0_a, req0_b);
      m_fl_id = e1; m_fl_res = r[63:0]; m_fl_cc = r[66:64];
      m_last = e1;
    end
    @(negedge clk);
  endtask

  task automatic idle(logic rr);
    drv(0, '0, '0, 2'b00, 0, '0, '0, 2'b00, rr);
  endtask

  task automatic one_op(logic port, logic [63:0] a, logic [63:0] b, logic [1:0] f,
                        logic [63:0] er, logic [2:0] ec, string tag);
    if (port) drv(0, '0, '0, 2'b00, 1, a, b, f, 1);
    else      drv(1, a, b, f, 0, '0, '0, 2'b00, 1);
    step();
    idle(1);
    step();
    #1;
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_res"}, rsp_result, er);
    chk({tag, "_cc"}, rsp_cc, ec);
    chk({tag, "_id"}, rsp_id, port);
    step();
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] x;
    rst_n = 1'b0;
    idle(0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_result", rsp_result, 64'd0);
    chk("rst_cc", rsp_cc, 3'b000);
    chk("rst_id", rsp_id, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset while an ADD is executing
    drv(1, 64'd3, 64'd4, ALU_ADD, 0, '0, '0, 2'b00, 1);
    step();
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", rsp_valid, 1'b0);
    model_reset();
    @(negedge clk);
    chk("midrst_result", rsp_result, 64'd0);
    rst_n = 1'b1;
    repeat (4) step();

    one_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD,
           64'h8000_0000_0000_0000, 3'b011, "add_ovf");
    one_op(0, 64'd5, 64'd5, ALU_SUB, 64'd0, 3'b100, "sub_zero");
    one_op(1, 64'h8000_0000_0000_0000, 64'd1, ALU_SUB,
           64'h7FFF_FFFF_FFFF_FFFF, 3'b001, "sub_ovf");

    // contention: both ports valid every cycle
    drv(1, 64'd10, 64'd20, ALU_ADD, 1, 64'd10, 64'd20, ALU_SUB, 1);
    repeat (12) step();
    idle(1);
    repeat (3) step();

    // backpressure, then same-cycle regrant on retire
    drv(1, 64'd2, 64'd3, ALU_ADD, 0, '0, '0, 2'b00, 1);
    step();
    drv(0, '0, '0, 2'b00, 1, 64'd9, 64'd4, ALU_SUB, 0);
    repeat (6) step();
    rsp_ready = 1'b1;
    step();
    chk("bp_regrant", g1, 1'b1);
    idle(1);
    step();
    #1;
    chk("bp_next_id", rsp_id, 1'b1);
    chk("bp_next_res", rsp_result, 64'd5);
    step();

    one_op(0, 64'hF0F0, 64'hFF00, ALU_AND, 64'hF000, 3'b000, "and");
    x = {$urandom(), $urandom()};
    one_op(1, x, x, ALU_XOR, 64'd0, 3'b100, "xor_self");

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if (!(req0_valid && !g0 && $urandom_range(0, 9) < 9)) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_a = rnd64(); req0_b = rnd64();
        req0_fun = 2'($urandom_range(0, 3));
      end
      if (!(req1_valid && !g1 && $urandom_range(0, 9) < 9)) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_a = rnd64(); req1_b = rnd64();
        req1_fun = 2'($urandom_range(0, 3));
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      if (i % 150 == 75) begin
        rst_n = 1'b0;
        #1;
        chk("rnd_rst_valid", rsp_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
